// File: rtl/i2c_target_rx.sv
// I2C target receiver: address match, write ACK, byte delivery over valid/ready,
// and clock stretching while a received byte waits for the consumer.
module i2c_target_rx #(
    parameter logic [6:0] ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_hold,
    output logic       sda_hold,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ADDR      = 3'd1;
    localparam logic [2:0] S_ADDR_ACK  = 3'd2;
    localparam logic [2:0] S_DATA      = 3'd3;
    localparam logic [2:0] S_STRETCH   = 3'd4;
    localparam logic [2:0] S_DATA_ACK  = 3'd5;
    localparam logic [2:0] S_WAIT_STOP = 3'd6;

    // [0] metastable, [1] synchronized, [2] history; reset to idle-high bus
    logic [2:0] scl_sr, sda_sr;
    logic       scl_s, scl_h, sda_s, sda_h;
    logic       scl_rise, scl_fall, start_c, stop_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= 3'b111;
            sda_sr <= 3'b111;
        end else begin
            scl_sr <= {scl_sr[1:0], scl_in};
            sda_sr <= {sda_sr[1:0], sda_in};
        end
    end

    assign scl_s    = scl_sr[1];
    assign scl_h    = scl_sr[2];
    assign sda_s    = sda_sr[1];
    assign sda_h    = sda_sr[2];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start_c  = scl_s & ~sda_s & sda_h;
    assign stop_c   = scl_s & sda_s & ~sda_h;

    logic [2:0] state, state_n;
    logic [2:0] cnt, cnt_n;
    logic       done, done_n;
    logic [7:0] shift, shift_n;
    logic       first, first_n;
    logic       scl_hold_n, sda_hold_n;
    logic [7:0] rx_data_n;
    logic       rx_valid_n, rx_first_n;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        done_n     = done;
        shift_n    = shift;
        first_n    = first;
        scl_hold_n = scl_hold;
        sda_hold_n = sda_hold;
        rx_data_n  = rx_data;
        rx_valid_n = rx_valid;
        rx_first_n = rx_first;
        if (rx_valid && rx_ready)
            rx_valid_n = 1'b0;
        // START/STOP win over a coincident SCL edge and abort any partial byte
        if (start_c || stop_c) begin
            state_n    = start_c ? S_ADDR : S_IDLE;
            cnt_n      = 3'd0;
            done_n     = 1'b0;
            sda_hold_n = 1'b0;
            scl_hold_n = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_DATA: begin
                    if (scl_rise && !done) begin
                        shift_n = {shift[6:0], sda_s};
                        cnt_n   = cnt + 3'd1;
                        done_n  = (cnt == 3'd7);
                    end else if (scl_fall && done) begin
                        if (state == S_ADDR) begin
                            if (shift[7:1] == ADDR && !shift[0]) begin
                                sda_hold_n = 1'b1;
                                state_n    = S_ADDR_ACK;
                            end else begin
                                state_n = S_WAIT_STOP;
                            end
                        end else begin
                            rx_data_n  = shift;
                            rx_valid_n = 1'b1;
                            rx_first_n = first;
                            first_n    = 1'b0;
                            scl_hold_n = 1'b1;
                            sda_hold_n = 1'b1;
                            state_n    = S_STRETCH;
                        end
                    end
                end
                S_ADDR_ACK: if (scl_fall) begin
                    sda_hold_n = 1'b0;
                    cnt_n      = 3'd0;
                    done_n     = 1'b0;
                    first_n    = 1'b1;
                    state_n    = S_DATA;
                end
                S_STRETCH: if (rx_valid && rx_ready) begin
                    scl_hold_n = 1'b0;
                    state_n    = S_DATA_ACK;
                end
                S_DATA_ACK: if (scl_fall) begin
                    sda_hold_n = 1'b0;
                    cnt_n      = 3'd0;
                    done_n     = 1'b0;
                    state_n    = S_DATA;
                end
                S_IDLE, S_WAIT_STOP: begin
                    scl_hold_n = 1'b0;
                    sda_hold_n = 1'b0;
                end
                default: begin
                    scl_hold_n = 1'b0;
                    sda_hold_n = 1'b0;
                    state_n    = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            done     <= 1'b0;
            shift    <= 8'd0;
            first    <= 1'b0;
            scl_hold <= 1'b0;
            sda_hold <= 1'b0;
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            done     <= done_n;
            shift    <= shift_n;
            first    <= first_n;
            scl_hold <= scl_hold_n;
            sda_hold <= sda_hold_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            rx_first <= rx_first_n;
            busy     <= (state_n != S_IDLE);
        end
    end

endmodule

// File: doc/i2c_target_rx.md
Name: i2c_target_rx

Overview:
- I2C target (slave) receiver that sits on the other end of the bus from the clock-stretching master clock generator.
- Samples SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs write transfers and delivers received bytes over a valid/ready handshake.
- Holds SCL low (clock stretching) after each data byte until the local consumer accepts it.
- Open-drain style: outputs are "pull low" enables; pad logic is external.

Parameters:
- ADDR, 7'h42, own 7-bit target address.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL from the pad (asynchronous).
- sda_in  in  1  raw SDA from the pad (asynchronous).
- scl_hold  out  1  1 = drive SCL low (stretch).
- sda_hold  out  1  1 = drive SDA low (ACK).
- rx_data  out  8  last received data byte, MSB first on the wire.
- rx_valid  out  1  rx_data holds an unconsumed byte.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_first  out  1  qualifies rx_data: first data byte after an address match.
- busy  out  1  1 in every state except IDLE.

Behaviour:
- Input synchronizers:
  - Two-flop synchronizer per input, then one history flop.
  - All flops reset to 1 (idle bus), so reset never produces a false START.
  - Edges are derived from the synchronized signal and its history flop.
- Bus conditions:
  - START: scl_s=1 and sda_s falling.
  - STOP: scl_s=1 and sda_s rising.
  - Data bit: sampled on scl_s rising edge.
  - Line drive changes only on scl_s falling edge, except where stated below.
- Registered outputs: all outputs are registered.
  - scl_hold/sda_hold change in the cycle after the synchronized edge is detected.
  - Latency from a raw pad edge to an output change is 3 clk.
- States:
  - IDLE: holds released. On START -> ADDR, bit counter = 0.
  - ADDR: shift 8 bits on SCL rising edges. On the falling edge after bit 8:
    - If bits[7:1]==ADDR and bit0 (R/W)==0: sda_hold=1, go to ADDR_ACK.
    - Otherwise: go to WAIT_STOP, no ACK. Reads are always NACKed.
  - ADDR_ACK: on next SCL falling edge: sda_hold=0, counter=0, first-flag=1, go to DATA.
  - DATA: shift 8 bits. On the falling edge after bit 8:
    - rx_data <= shift register, rx_valid=1, rx_first <= first-flag.
    - first-flag=0, scl_hold=1, sda_hold=1 (ACK driven while stretched), go to STRETCH.
  - STRETCH: scl_hold stays 1 until the handshake cycle (rx_valid && rx_ready).
    - In that cycle: rx_valid=0 and scl_hold=0 next cycle.
    - sda_hold stays 1. Go to DATA_ACK.
    - Minimum stretch is 1 clk, even if rx_ready is already high.
  - DATA_ACK: on next SCL falling edge: sda_hold=0, counter=0, go to DATA.
  - WAIT_STOP: holds released; wait for START or STOP.
- Global events, any state except STRETCH:
  - START: -> ADDR, counter=0, sda_hold=0. Covers repeated START.
  - STOP: -> IDLE, sda_hold=0. A partial byte is discarded.
  - START/STOP cannot occur in STRETCH because SCL is held low. If seen (external fault), the same rule applies and scl_hold is released.
- rx_valid:
  - Independent of bus state once set; cleared only by handshake or rst.
  - rx_data and rx_first are stable while rx_valid=1.
- Counter: 3-bit bit counter plus a done flag. No wrap ambiguity: the 9th clock is always the ACK slot.
- Reset: state IDLE; scl_hold=sda_hold=rx_valid=rx_first=busy=0; rx_data=0; shift register 0.
  - Reset mid-transfer releases both lines on the reset cycle edge.
- Simultaneous events:
  - The handshake in the same cycle as an SCL edge is impossible in STRETCH.
  - An SCL rise together with a START/STOP is treated as the START/STOP.

Test Plan:
- START, addr 0x84 (0x42 write), byte 0xA5, rx_ready=1, STOP:
  - sda_hold=1 during both ACK slots.
  - rx_data=0xA5, rx_valid and rx_first for one cycle, scl_hold high exactly 1 clk.
  - busy returns to 0 after STOP.
- Same transfer with rx_ready=0 for 200 clk:
  - scl_hold stays 1 for ≥200 clk and rx_data stays 0xA5.
  - scl_hold=0 the cycle after rx_ready rises; master completes the ACK bit.
- Address 0x86 (0x43 write), then byte 0x11:
  - sda_hold never asserted, rx_valid stays 0.
  - State WAIT_STOP until STOP, then IDLE.
- Address 0x85 (0x42 read): NACK (sda_hold=0 in ACK slot), no rx_valid.
- Two bytes 0x01, 0x02, then repeated START + address 0x84, byte 0x03:
  - rx_first=1 for 0x01 and 0x03, 0 for 0x02. Three ACKs after data.
- rst pulsed after 4 data bits; or STOP after 5 bits:
  - All outputs released, no rx_valid, next START/0x84 transfer received correctly.
